vm_change_dispenser: RTL and testbench
======================================

Name: vm_change_dispenser

Overview:
- Sequences change payout for the vending machine and owns the denomination inventory.
- On a change request it first runs a greedy plan, largest to smallest denomination, limited by the coins and notes on hand.
- Dispensing starts only if the plan reaches exactly zero; one item is then issued per ready/valid handshake to the payout mechanism.
- Inserted coins and notes are counted into the same inventory through a deposit port. All amounts are in cents.

Parameters:
AMT_W, 20, width of change amount in cents
CNT_W, 8, width of each inventory counter (saturating)
INIT_CNT, -1, reset count for all 15 denominations; -1 means use the DENOMINATION_AMOUNT_* values from vm_parameter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
chg_req  in  1  start request, sampled only when chg_ready=1
chg_amount  in  AMT_W  change in cents, captured with chg_req
chg_ready  out  1  high in IDLE only
chg_done  out  1  1-cycle pulse: full change dispensed
chg_fail  out  1  1-cycle pulse: exact change impossible, nothing dispensed
disp_valid  out  1  item to dispense is presented
disp_code  out  4  denomination code 1..15 (1=500.00 ... 15=0.01)
disp_ready  in  1  payout mechanism accepts item
dep_valid  in  1  deposit strobe, any state
dep_code  in  4  deposited denomination code
dep_err  out  1  1-cycle pulse: dep_code is 0, or the counter is saturated (deposit not counted)
inv_empty  out  15  bit i-1 high when count of code i == 0

Behaviour:
- Reset (async, any state):
  - state=IDLE; chg_ready=1; all other outputs 0; disp_code=0.
  - Plan counters and remainder cleared.
  - Inventory reloaded per INIT_CNT.
- States: IDLE, PLAN, CHECK, DISPENSE, DONE, FAIL.
- IDLE: on chg_req, capture rem=chg_amount and idx=1, then go to PLAN. chg_ready drops the next cycle.
- PLAN: one decision per cycle.
  - If rem>=val(idx) and plan[idx]<inv[idx]: plan[idx]++ and rem-=val(idx).
  - Else if idx==15: go to CHECK.
  - Else: idx++.
- CHECK:
  - If rem==0: idx=1 and go to DISPENSE.
  - Else: clear all plan[] and go to FAIL.
- DISPENSE:
  - If plan[idx]==0: advance idx one per cycle. If idx==15, go to DONE instead.
  - Else: disp_valid=1 and disp_code=idx, driven from registers.
  - On disp_valid&&disp_ready: plan[idx]-- and inv[idx]--.
  - disp_valid/disp_code hold stable until accepted. Back-to-back accepts of the same code are allowed every cycle.
- DONE: chg_done=1 for one cycle, then IDLE. FAIL: chg_fail=1 for one cycle, then IDLE.
- chg_amount==0: PLAN walks all codes, CHECK passes, DISPENSE walks with no disp_valid, then chg_done.
- Deposits:
  - Valid codes 1..15 increment inv[code] in any state.
  - Counters saturate at 2^CNT_W-1. The saturated case and code 0 both pulse dep_err with no change.
  - Planning stays safe because deposits only increase counts.
- Deposit and dispense on the same code in the same cycle: net count unchanged, no dep_err unless the counter is saturated.
- Widths:
  - Values up to 50000 need 16 bits and are zero-extended to AMT_W.
  - The rem subtract never underflows, because it is guarded by the compare.
- Fail leaves the inventory untouched.

Decomposition:
- Additions to vm_parameter:
  - State enum.
  - Function denom_value(code), returning the code→cents lookup from DENOMINATION_VALUE_*.
  - Function denom_init(code), returning DENOMINATION_AMOUNT_*.
  - Localparam NUM_DENOM=15.
- Sub-module vm_denom_inventory:
  - 15 saturating counters with one increment port (deposit) and one decrement port (dispense).
  - Provides simultaneous inc/dec resolution, a saturation flag, count read by index, and inv_empty.

Test Plan:
- Package counts: chg_amount=180 → disp_code sequence 9,10,11,13 (1.00, 0.50, 0.25, 0.05), then chg_done. Each of those counts drops 100→99.
- INIT_CNT=1: chg_amount=4 → plan 2+1 leaves rem=1 → chg_fail. No disp_valid, inventory unchanged.
- INIT_CNT=1: chg_amount=88 → codes 10,11,12,14,15 then chg_done. inv_empty bits for those codes set.
- chg_amount=200, disp_ready low for 5 cycles → disp_valid=1 with code 8 held stable. Accept on cycle 6 → chg_done; count of code 8 is 99.
- INIT_CNT=255: dep_code=3 → dep_err pulse, count stays 255. dep_code=0 → dep_err pulse. Deposit code 9 during a code-9 dispense handshake → count unchanged.
- Assert rst_n low mid-DISPENSE → disp_valid=0 immediately, chg_ready=1, counts back to 100.

Source files
------------

// File: rtl/vm_change_dispenser_pkg.sv
// Shared definitions for the change dispenser: denomination table, reset inventory
// and the sequencer state encoding.
//   NUM_DENOM           number of denomination codes (1..15, code 0 is invalid)
//   denom_value(code)   value of a denomination in cents (0 for code 0)
//   denom_init(code)    default reset inventory count for a denomination
package vm_change_dispenser_pkg;

    localparam int NUM_DENOM = 15;

    // Denomination values in cents, code 1 is the largest.
    localparam logic [15:0] DENOMINATION_VALUE_1  = 16'd50000;
    localparam logic [15:0] DENOMINATION_VALUE_2  = 16'd20000;
    localparam logic [15:0] DENOMINATION_VALUE_3  = 16'd10000;
    localparam logic [15:0] DENOMINATION_VALUE_4  = 16'd5000;
    localparam logic [15:0] DENOMINATION_VALUE_5  = 16'd2000;
    localparam logic [15:0] DENOMINATION_VALUE_6  = 16'd1000;
    localparam logic [15:0] DENOMINATION_VALUE_7  = 16'd500;
    localparam logic [15:0] DENOMINATION_VALUE_8  = 16'd200;
    localparam logic [15:0] DENOMINATION_VALUE_9  = 16'd100;
    localparam logic [15:0] DENOMINATION_VALUE_10 = 16'd50;
    localparam logic [15:0] DENOMINATION_VALUE_11 = 16'd25;
    localparam logic [15:0] DENOMINATION_VALUE_12 = 16'd10;
    localparam logic [15:0] DENOMINATION_VALUE_13 = 16'd5;
    localparam logic [15:0] DENOMINATION_VALUE_14 = 16'd2;
    localparam logic [15:0] DENOMINATION_VALUE_15 = 16'd1;

    // Default stock loaded at reset.
    localparam int unsigned DENOMINATION_AMOUNT_1  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_2  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_3  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_4  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_5  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_6  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_7  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_8  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_9  = 100;
    localparam int unsigned DENOMINATION_AMOUNT_10 = 100;
    localparam int unsigned DENOMINATION_AMOUNT_11 = 100;
    localparam int unsigned DENOMINATION_AMOUNT_12 = 100;
    localparam int unsigned DENOMINATION_AMOUNT_13 = 100;
    localparam int unsigned DENOMINATION_AMOUNT_14 = 100;
    localparam int unsigned DENOMINATION_AMOUNT_15 = 100;

    typedef enum logic [2:0] {
        StIdle,
        StPlan,
        StCheck,
        StDispense,
        StDone,
        StFail
    } chg_state_e;

    function automatic logic [15:0] denom_value(input logic [3:0] code);
        case (code)
            4'd1:    return DENOMINATION_VALUE_1;
            4'd2:    return DENOMINATION_VALUE_2;
            4'd3:    return DENOMINATION_VALUE_3;
            4'd4:    return DENOMINATION_VALUE_4;
            4'd5:    return DENOMINATION_VALUE_5;
            4'd6:    return DENOMINATION_VALUE_6;
            4'd7:    return DENOMINATION_VALUE_7;
            4'd8:    return DENOMINATION_VALUE_8;
            4'd9:    return DENOMINATION_VALUE_9;
            4'd10:   return DENOMINATION_VALUE_10;
            4'd11:   return DENOMINATION_VALUE_11;
            4'd12:   return DENOMINATION_VALUE_12;
            4'd13:   return DENOMINATION_VALUE_13;
            4'd14:   return DENOMINATION_VALUE_14;
            4'd15:   return DENOMINATION_VALUE_15;
            default: return 16'd0;
        endcase
    endfunction

    function automatic int unsigned denom_init(input logic [3:0] code);
        case (code)
            4'd1:    return DENOMINATION_AMOUNT_1;
            4'd2:    return DENOMINATION_AMOUNT_2;
            4'd3:    return DENOMINATION_AMOUNT_3;
            4'd4:    return DENOMINATION_AMOUNT_4;
            4'd5:    return DENOMINATION_AMOUNT_5;
            4'd6:    return DENOMINATION_AMOUNT_6;
            4'd7:    return DENOMINATION_AMOUNT_7;
            4'd8:    return DENOMINATION_AMOUNT_8;
            4'd9:    return DENOMINATION_AMOUNT_9;
            4'd10:   return DENOMINATION_AMOUNT_10;
            4'd11:   return DENOMINATION_AMOUNT_11;
            4'd12:   return DENOMINATION_AMOUNT_12;
            4'd13:   return DENOMINATION_AMOUNT_13;
            4'd14:   return DENOMINATION_AMOUNT_14;
            4'd15:   return DENOMINATION_AMOUNT_15;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vm_denom_inventory.sv
// Denomination inventory: one saturating counter per code 1..15.
//   clk, rst_n      clock, asynchronous active-low reset (reloads the initial stock)
//   inc_valid/code  deposit increment; ignored and flagged when code is 0 or saturated
//   inc_err         combinational: the current increment request will not be counted
//   dec_valid/code  dispense decrement
//   rd_code/rd_cnt  count read by index (rd_cnt is 0 for code 0)
//   empty           bit i-1 high when count of code i is zero
module vm_denom_inventory
    import vm_change_dispenser_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int          INIT_CNT = -1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_valid,
    input  logic [3:0]           inc_code,
    output logic                 inc_err,
    input  logic                 dec_valid,
    input  logic [3:0]           dec_code,
    input  logic [3:0]           rd_code,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [NUM_DENOM-1:0] empty
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0]     cnt_q [1:NUM_DENOM];
    logic [NUM_DENOM:1]   inc_hit;
    logic [NUM_DENOM:1]   dec_hit;
    logic                 inc_sat;

    function automatic logic [CNT_W-1:0] reset_cnt(input logic [3:0] code);
        if (INIT_CNT < 0) begin
            return CNT_W'(denom_init(code));
        end
        return CNT_W'(INIT_CNT);
    endfunction

    always_comb begin
        rd_cnt  = '0;
        inc_sat = 1'b0;
        empty   = '0;
        for (int i = 1; i <= NUM_DENOM; i++) begin
            if (rd_code == 4'(i)) begin
                rd_cnt = cnt_q[i];
            end
            if (inc_code == 4'(i)) begin
                inc_sat = (cnt_q[i] == CntMax);
            end
            empty[i-1] = (cnt_q[i] == '0);
        end
    end

    assign inc_err = inc_valid && ((inc_code == 4'd0) || inc_sat);

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        for (int i = 1; i <= NUM_DENOM; i++) begin
            inc_hit[i] = inc_valid && !inc_err && (inc_code == 4'(i));
            // Never wrap below zero, even if the sequencer misbehaves.
            dec_hit[i] = dec_valid && (dec_code == 4'(i)) && (cnt_q[i] != '0);
        end
    end

    // A simultaneous increment and decrement on one code cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NUM_DENOM; i++) begin
                cnt_q[i] <= reset_cnt(4'(i));
            end
        end else begin
            for (int i = 1; i <= NUM_DENOM; i++) begin
                if (inc_hit[i] && !dec_hit[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (dec_hit[i] && !inc_hit[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change payout sequencer. A request runs a greedy plan (largest code first, limited by
// stock); only an exact plan is dispensed, one item per disp_valid/disp_ready handshake.
//   clk, rst_n           clock, asynchronous active-low reset
//   chg_req/chg_amount   change request and amount in cents, taken while chg_ready
//   chg_ready            high while idle
//   chg_done/chg_fail    one-cycle completion / impossible-change pulses
//   disp_valid/code      item presented to the payout mechanism, disp_ready accepts
//   dep_valid/dep_code   deposit of one coin or note, accepted in any state
//   dep_err              one-cycle pulse: deposit not counted (code 0 or saturated)
//   inv_empty            bit i-1 high when code i is out of stock
module vm_change_dispenser
    import vm_change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W    = 20,
    parameter int unsigned CNT_W    = 8,
    parameter int          INIT_CNT = -1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chg_req,
    input  logic [AMT_W-1:0]     chg_amount,
    output logic                 chg_ready,
    output logic                 chg_done,
    output logic                 chg_fail,
    output logic                 disp_valid,
    output logic [3:0]           disp_code,
    input  logic                 disp_ready,
    input  logic                 dep_valid,
    input  logic [3:0]           dep_code,
    output logic                 dep_err,
    output logic [NUM_DENOM-1:0] inv_empty
);

    chg_state_e       state_q;
    logic [AMT_W-1:0] rem_q;
    logic [3:0]       idx_q;
    logic [CNT_W-1:0] plan_q [1:NUM_DENOM];

    logic [CNT_W-1:0] plan_cur;
    logic [CNT_W-1:0] inv_cnt;
    logic [AMT_W-1:0] idx_val;
    logic             accept;
    logic             inc_err;

    assign idx_val = AMT_W'(denom_value(idx_q));
    assign accept  = disp_valid && disp_ready;

    always_comb begin
        plan_cur = '0;
        for (int i = 1; i <= NUM_DENOM; i++) begin
            if (idx_q == 4'(i)) begin
                plan_cur = plan_q[i];
            end
        end
    end

    vm_denom_inventory #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_inv (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_valid (dep_valid),
        .inc_code  (dep_code),
        .inc_err   (inc_err),
        .dec_valid (accept),
        .dec_code  (disp_code),
        .rd_code   (idx_q),
        .rd_cnt    (inv_cnt),
        .empty     (inv_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            idx_q      <= 4'd1;
            chg_ready  <= 1'b1;
            chg_done   <= 1'b0;
            chg_fail   <= 1'b0;
            disp_valid <= 1'b0;
            disp_code  <= 4'd0;
            dep_err    <= 1'b0;
            for (int i = 1; i <= NUM_DENOM; i++) begin
                plan_q[i] <= '0;
            end
        end else begin
            chg_done <= 1'b0;
            chg_fail <= 1'b0;
            dep_err  <= inc_err;
            unique case (state_q)
                StIdle: begin
                    if (chg_req) begin
                        rem_q     <= chg_amount;
                        idx_q     <= 4'd1;
                        chg_ready <= 1'b0;
                        state_q   <= StPlan;
                    end
                end
                StPlan: begin
                    // Compare guards the subtract, so rem_q never underflows.
                    if ((rem_q >= idx_val) && (plan_cur < inv_cnt)) begin
                        plan_q[idx_q] <= plan_cur + 1'b1;
                        rem_q         <= rem_q - idx_val;
                    end else if (idx_q == 4'(NUM_DENOM)) begin
                        state_q <= StCheck;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                StCheck: begin
                    if (rem_q == '0) begin
                        idx_q   <= 4'd1;
                        state_q <= StDispense;
                    end else begin
                        for (int i = 1; i <= NUM_DENOM; i++) begin
                            plan_q[i] <= '0;
                        end
                        chg_fail <= 1'b1;
                        state_q  <= StFail;
                    end
                end
                StDispense: begin
                    if (disp_valid) begin
                        if (disp_ready) begin
                            plan_q[idx_q] <= plan_cur - 1'b1;
                            // Keep valid up for back-to-back items of the same code.
                            if (plan_cur == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                                disp_valid <= 1'b0;
                                disp_code  <= 4'd0;
                            end
                        end
                    end else if (plan_cur == '0) begin
                        if (idx_q == 4'(NUM_DENOM)) begin
                            chg_done <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else begin
                        disp_valid <= 1'b1;
                        disp_code  <= idx_q;
                    end
                end
                StDone, StFail: begin
                    chg_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    chg_ready <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
module tb_vm_change_dispenser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chg_req = 1'b0;
    logic [19:0] chg_amount = '0;
    logic        disp_ready = 1'b0;
    logic        dep_valid = 1'b0;
    logic [3:0]  dep_code = 4'd0;

    logic [2:0]        chg_ready, chg_done, chg_fail, disp_valid, dep_err;
    logic [2:0][3:0]   disp_code;
    logic [2:0][14:0]  inv_empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Three stock configurations share one stimulus stream: default (100), 1 each, 255 each.
    vm_change_dispenser #(.AMT_W(20), .CNT_W(8), .INIT_CNT(-1)) dut0 (
        .clk(clk), .rst_n(rst_n), .chg_req(chg_req), .chg_amount(chg_amount),
        .chg_ready(chg_ready[0]), .chg_done(chg_done[0]), .chg_fail(chg_fail[0]),
        .disp_valid(disp_valid[0]), .disp_code(disp_code[0]), .disp_ready(disp_ready),
        .dep_valid(dep_valid), .dep_code(dep_code), .dep_err(dep_err[0]),
        .inv_empty(inv_empty[0])
    );
    vm_change_dispenser #(.AMT_W(20), .CNT_W(8), .INIT_CNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .chg_req(chg_req), .chg_amount(chg_amount),
        .chg_ready(chg_ready[1]), .chg_done(chg_done[1]), .chg_fail(chg_fail[1]),
        .disp_valid(disp_valid[1]), .disp_code(disp_code[1]), .disp_ready(disp_ready),
        .dep_valid(dep_valid), .dep_code(dep_code), .dep_err(dep_err[1]),
        .inv_empty(inv_empty[1])
    );
    vm_change_dispenser #(.AMT_W(20), .CNT_W(8), .INIT_CNT(255)) dut2 (
        .clk(clk), .rst_n(rst_n), .chg_req(chg_req), .chg_amount(chg_amount),
        .chg_ready(chg_ready[2]), .chg_done(chg_done[2]), .chg_fail(chg_fail[2]),
        .disp_valid(disp_valid[2]), .disp_code(disp_code[2]), .disp_ready(disp_ready),
        .dep_valid(dep_valid), .dep_code(dep_code), .dep_err(dep_err[2]),
        .inv_empty(inv_empty[2])
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [19:0] amount;
        logic        exp_fail;
        logic [4:0]  exp_n;
        logic [63:0] seq;        // expected codes, first item in the highest used nibble
        logic [14:0] exp_empty;
        logic [3:0]  chk_code;
        logic [7:0]  exp_cnt;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_of(input int sel, input int code);
        case (sel)
            0:       return dut0.u_inv.cnt_q[code];
            1:       return dut1.u_inv.cnt_q[code];
            default: return dut2.u_inv.cnt_q[code];
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        chg_req = 1'b0;
        dep_valid = 1'b0;
        disp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(input logic [19:0] amt);
        chg_amount = amt;
        chg_req = 1'b1;
        @(negedge clk);
        chg_req = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (disp_valid[sel]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int sel, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (chg_done[sel]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        vecs[0] = '{sel:2'd0, amount:20'd180,    exp_fail:1'b0, exp_n:5'd4, seq:64'h9ABD,
                   exp_empty:15'h0,    chk_code:4'd9,  exp_cnt:8'd99};
        vecs[1] = '{sel:2'd1, amount:20'd4,      exp_fail:1'b1, exp_n:5'd0, seq:64'h0,
                   exp_empty:15'h0,    chk_code:4'd14, exp_cnt:8'd1};
        vecs[2] = '{sel:2'd1, amount:20'd88,     exp_fail:1'b0, exp_n:5'd5, seq:64'hABCEF,
                   exp_empty:15'h6E00, chk_code:4'd12, exp_cnt:8'd0};
        vecs[3] = '{sel:2'd0, amount:20'd0,      exp_fail:1'b0, exp_n:5'd0, seq:64'h0,
                   exp_empty:15'h0,    chk_code:4'd1,  exp_cnt:8'd100};
        vecs[4] = '{sel:2'd0, amount:20'd77777,  exp_fail:1'b0, exp_n:5'd9, seq:64'h124578ABE,
                   exp_empty:15'h0,    chk_code:4'd2,  exp_cnt:8'd99};
        vecs[5] = '{sel:2'd1, amount:20'd3,      exp_fail:1'b0, exp_n:5'd2, seq:64'hEF,
                   exp_empty:15'h6000, chk_code:4'd13, exp_cnt:8'd1};
        vecs[6] = '{sel:2'd1, amount:20'd100000, exp_fail:1'b1, exp_n:5'd0, seq:64'h0,
                   exp_empty:15'h0,    chk_code:4'd1,  exp_cnt:8'd1};
        vecs[7] = '{sel:2'd0, amount:20'd150000, exp_fail:1'b0, exp_n:5'd3, seq:64'h111,
                   exp_empty:15'h0,    chk_code:4'd1,  exp_cnt:8'd97};

        // Reset state, observed while reset is held.
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst chg_ready[%0d]", d), chg_ready[d], 1);
            check($sformatf("rst disp_valid[%0d]", d), disp_valid[d], 0);
            check($sformatf("rst disp_code[%0d]", d), disp_code[d], 0);
            check($sformatf("rst done/fail/err[%0d]", d),
                  {chg_done[d], chg_fail[d], dep_err[d]}, 0);
        end
        check("rst cnt dut0 code5", cnt_of(0, 5), 100);
        check("rst cnt dut2 code5", cnt_of(2, 5), 255);

        // Table-driven change requests with free-running payout.
        for (int v = 0; v < NV; v++) begin
            int          sel;
            int          got;
            bit          finished;
            logic        done_v;
            logic        fail_v;
            logic [3:0]  seen [16];
            logic [63:0] s;
            sel = int'(vecs[v].sel);
            got = 0;
            finished = 1'b0;
            done_v = 1'b0;
            fail_v = 1'b0;
            do_reset();
            start(vecs[v].amount);
            check($sformatf("v%0d chg_ready low", v), chg_ready[sel], 0);
            for (int c = 0; c < 400 && !finished; c++) begin
                if (disp_valid[sel]) begin
                    if (got < 16) seen[got] = disp_code[sel];
                    got++;
                end
                if (chg_done[sel] || chg_fail[sel]) begin
                    finished = 1'b1;
                    done_v = chg_done[sel];
                    fail_v = chg_fail[sel];
                end
                @(negedge clk);
            end
            check($sformatf("v%0d finished", v), finished, 1);
            check($sformatf("v%0d chg_fail", v), fail_v, vecs[v].exp_fail);
            check($sformatf("v%0d chg_done", v), done_v, !vecs[v].exp_fail);
            check($sformatf("v%0d item count", v), got, vecs[v].exp_n);
            s = vecs[v].seq;
            for (int k = 0; k < int'(vecs[v].exp_n) && k < got && k < 16; k++) begin
                check($sformatf("v%0d item %0d code", v, k), seen[k],
                      s[4*(int'(vecs[v].exp_n)-1-k) +: 4]);
            end
            check($sformatf("v%0d inv_empty", v), inv_empty[sel], vecs[v].exp_empty);
            check($sformatf("v%0d count code %0d", v, vecs[v].chk_code),
                  cnt_of(sel, int'(vecs[v].chk_code)), vecs[v].exp_cnt);
            check($sformatf("v%0d chg_ready back", v), chg_ready[sel], 1);
        end

        // Stalled payout: item must hold stable until accepted.
        do_reset();
        disp_ready = 1'b0;
        start(20'd200);
        wait_valid(0, ok);
        check("stall valid seen", ok, 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall hold valid %0d", k), disp_valid[0], 1);
            check($sformatf("stall hold code %0d", k), disp_code[0], 8);
            @(negedge clk);
        end
        disp_ready = 1'b1;
        @(negedge clk);
        check("stall valid drops after accept", disp_valid[0], 0);
        wait_done(0, ok);
        check("stall done", ok, 1);
        check("stall count code8", cnt_of(0, 8), 99);

        // Deposits: saturation, code 0, normal increment.
        do_reset();
        dep_code = 4'd3;
        dep_valid = 1'b1;
        @(negedge clk);
        dep_valid = 1'b0;
        check("dep sat dep_err", dep_err[2], 1);
        check("dep normal dep_err", dep_err[0], 0);
        check("dep sat count", cnt_of(2, 3), 255);
        check("dep normal count", cnt_of(0, 3), 101);
        @(negedge clk);
        check("dep_err is a pulse", dep_err[2], 0);
        dep_code = 4'd0;
        dep_valid = 1'b1;
        @(negedge clk);
        dep_valid = 1'b0;
        check("dep code0 dep_err dut2", dep_err[2], 1);
        check("dep code0 dep_err dut0", dep_err[0], 1);

        // Deposit and dispense of the same code in one cycle.
        do_reset();
        disp_ready = 1'b0;
        start(20'd100);
        wait_valid(0, ok);
        check("simul valid seen", ok, 1);
        check("simul code", disp_code[0], 9);
        dep_code = 4'd9;
        dep_valid = 1'b1;
        disp_ready = 1'b1;
        @(negedge clk);
        dep_valid = 1'b0;
        check("simul dep_err", dep_err[0], 0);
        check("simul count code9", cnt_of(0, 9), 100);
        wait_done(0, ok);
        check("simul done", ok, 1);

        // Asynchronous reset in the middle of dispensing.
        do_reset();
        disp_ready = 1'b0;
        start(20'd300);
        wait_valid(0, ok);
        check("rstmid first valid", ok, 1);
        check("rstmid first code", disp_code[0], 8);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        wait_valid(0, ok);
        check("rstmid second valid", ok, 1);
        check("rstmid second code", disp_code[0], 9);
        check("rstmid count code8 before", cnt_of(0, 8), 99);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid disp_valid", disp_valid[0], 0);
        check("rstmid chg_ready", chg_ready[0], 1);
        check("rstmid count code8 after", cnt_of(0, 8), 100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
